// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between a memory master (e.g. the matmul engine)
//   and the mem_responder target.
//   mem_req       : request strobe, one request per clock
//   mem_write     : 1 = write, 0 = read (qualified by mem_req)
//   mem_addr      : word address
//   mem_wdata     : write data
//   mem_rdata_vld : read data valid, one-cycle pulse per read
//   mem_rdata     : read data, zero when mem_rdata_vld is low
// ----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32
);
    logic              mem_req;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic              mem_rdata_vld;
    logic [MEM_DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_write, mem_addr, mem_wdata,
        input  mem_rdata_vld, mem_rdata
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_wdata,
        output mem_rdata_vld, mem_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Single-port memory target with fixed read latency and a built-in init
//   sequencer that fills mem[i] = i after reset or on i_init_go.
//
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : mem_responder_if.slave (request in, read data out)
//   i_init_go   : pulse, starts an init sequence from READY
//   o_init_busy : high while the init sequence runs
//   o_req_err   : one-cycle pulse after a request dropped outside READY
//
//   Optional build macro MEM_RESP_STATS_EN adds:
//   o_rd_cnt / o_wr_cnt : accepted reads / writes (wrapping, 32 bit)
//   o_err_cnt           : o_req_err pulses (saturating, 16 bit)
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int MEM_AW      = 16,
    parameter int MEM_DW      = 32,
    parameter int DEPTH_LOG2  = 12,
    parameter int RD_LAT      = 2,
    parameter bit INIT_ON_RST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_responder_if.slave         bus,
    input  logic                   i_init_go,
    output logic                   o_init_busy,
    output logic                   o_req_err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]            o_rd_cnt,
    output logic [31:0]            o_wr_cnt,
    output logic [15:0]            o_err_cnt
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_READY} state_t;

    state_t                  r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0]   r_cnt;
    logic                    r_init_pend;
    logic                    r_req_err;
    logic [RD_LAT-1:0]       r_vld_pipe;
    logic [MEM_DW-1:0]       r_data_pipe [RD_LAT];
    logic [MEM_DW-1:0]       r_mem       [DEPTH];

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_ready, w_rd_acc, w_wr_acc, w_init_wr;
    logic                    w_go, w_init_last;

    // Upper address bits are dropped: the array aliases every DEPTH words.
    assign w_idx       = bus.mem_addr[DEPTH_LOG2-1:0];
    assign w_init_last = &r_cnt;
    // Init may only start once nothing is left in the read pipe, including a
    // read being accepted this very cycle.
    assign w_go        = (i_init_go | r_init_pend) & ~(|r_vld_pipe) & ~w_rd_acc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = INIT_ON_RST ? S_INIT : S_READY;
            S_INIT:  if (w_init_last) w_state_nxt = S_READY;
            S_READY: if (w_go)        w_state_nxt = S_INIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready     = (r_state == S_READY);
        w_init_wr   = (r_state == S_INIT);
        w_rd_acc    = w_ready & bus.mem_req & ~bus.mem_write;
        w_wr_acc    = w_ready & bus.mem_req &  bus.mem_write;
        o_init_busy = w_init_wr;
    end

    // ---------------- control / read pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_init_pend <= 1'b0;
            r_req_err   <= 1'b0;
            r_vld_pipe  <= '0;
            for (int k = 0; k < RD_LAT; k++) r_data_pipe[k] <= '0;
        end else begin
            r_cnt     <= w_init_wr ? r_cnt + 1'b1 : '0;
            r_req_err <= bus.mem_req & ~w_ready;

            // init_go seen while reads drain is remembered until w_go fires
            if (!w_ready || w_go) r_init_pend <= 1'b0;
            else if (i_init_go)   r_init_pend <= 1'b1;

            // Stage 0 samples the array at the accepting edge; idle slots
            // carry zero so the output is clean without extra gating.
            r_vld_pipe[0]  <= w_rd_acc;
            r_data_pipe[0] <= w_rd_acc ? r_mem[w_idx] : '0;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld_pipe[k]  <= r_vld_pipe[k-1];
                r_data_pipe[k] <= r_data_pipe[k-1];
            end
        end
    end

    // Array is not reset; init and host writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (w_init_wr)     r_mem[r_cnt] <= MEM_DW'(r_cnt);
        else if (w_wr_acc) r_mem[w_idx] <= bus.mem_wdata;
    end

    assign bus.mem_rdata_vld = r_vld_pipe[RD_LAT-1];
    assign bus.mem_rdata     = r_vld_pipe[RD_LAT-1] ? r_data_pipe[RD_LAT-1] : '0;
    assign o_req_err         = r_req_err;

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_cnt  <= '0;
            o_wr_cnt  <= '0;
            o_err_cnt <= '0;
        end else begin
            if (w_rd_acc) o_rd_cnt <= o_rd_cnt + 1'b1;
            if (w_wr_acc) o_wr_cnt <= o_wr_cnt + 1'b1;
            if (r_req_err && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder with default parameters
//   (DEPTH_LOG2=12, RD_LAT=2, INIT_ON_RST=1). Inputs change on the falling
//   edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mem_responder;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic init_go;
    logic init_busy;
    logic req_err;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt, wr_cnt;
    logic [15:0] err_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

    mem_responder #(
        .MEM_AW(AW), .MEM_DW(DW), .DEPTH_LOG2(12), .RD_LAT(RL), .INIT_ON_RST(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .i_init_go   (init_go),
        .o_init_busy (init_busy),
        .o_req_err   (req_err)
`ifdef MEM_RESP_STATS_EN
        ,
        .o_rd_cnt    (rd_cnt),
        .o_wr_cnt    (wr_cnt),
        .o_err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_write = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
        @(negedge clk);
        bus.mem_req = 1'b0; bus.mem_write = 1'b0;
    endtask

    // Read, expect vld RD_LAT-1 falling edges after the accepting edge's
    // falling edge, with data, then a single-cycle pulse.
    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int lat;
        logic [DW-1:0] d;
        lat = -1; d = '0;
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_write = 1'b0; bus.mem_addr = a;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.mem_req = 1'b0;
            if (bus.mem_rdata_vld) begin lat = k; d = bus.mem_rdata; break; end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(RL - 1));
        chk({tag, "_data"}, 64'(d), 64'(exp));
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, bus.mem_rdata_vld, bus.mem_rdata}, 64'd0);
    endtask

    // Observe one init sequence (bounded); optionally inject a read at a
    // given busy count.
    task automatic run_init(input int inject_at, output int nbusy, output int nerr,
                            output int nvld, output logic [DW-1:0] lastd);
        bit seen;
        seen = 1'b0; nbusy = 0; nerr = 0; nvld = 0; lastd = '0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (init_busy) nbusy++;
            if (req_err) nerr++;
            if (bus.mem_rdata_vld) begin nvld++; lastd = bus.mem_rdata; end
            init_go       = 1'b0;
            bus.mem_write = 1'b0;
            bus.mem_addr  = 16'h0010;
            bus.mem_req   = (inject_at >= 0) && init_busy && (nbusy == inject_at);
            if (init_busy) seen = 1'b1;
            else if (seen) break;
        end
        bus.mem_req = 1'b0;
    endtask

    initial begin
        int nb, ne, nv;
        logic [DW-1:0] ld;

        rst_n = 1'b0; init_go = 1'b0;
        bus.mem_req = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld",   64'(bus.mem_rdata_vld), 64'd0);
        chk("rst_rdata", 64'(bus.mem_rdata),     64'd0);
        chk("rst_busy",  64'(init_busy),         64'd0);
        chk("rst_err",   64'(req_err),           64'd0);

        // power-up init with a dropped read in the middle
        rst_n = 1'b1;
        run_init(100, nb, ne, nv, ld);
        chk("init_busy_cycles", 64'(nb), 64'd4096);
        chk("init_req_err",     64'(ne), 64'd1);
        chk("init_no_vld",      64'(nv), 64'd0);

        rd_check("rd_123", 16'h0123, 32'h0000_0123);
`ifdef MEM_RESP_STATS_EN
        chk("stat_rd",  64'(rd_cnt),  64'd1);
        chk("stat_wr",  64'(wr_cnt),  64'd0);
        chk("stat_err", 64'(err_cnt), 64'd1);
`endif

        // 16 back-to-back reads; vld lags issue by two falling edges
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 2 && i < 18)
                chk("burst", {31'd0, bus.mem_rdata_vld, bus.mem_rdata}, {31'd0, 1'b1, 32'h100 + 32'(i - 2)});
            else
                chk("burst_idle", {31'd0, bus.mem_rdata_vld, bus.mem_rdata}, 64'd0);
            bus.mem_req = (i < 16); bus.mem_write = 1'b0; bus.mem_addr = 16'h0100 + 16'(i);
        end
        bus.mem_req = 1'b0;

        // write at edge n, read at edge n+1
        wr(16'h0105, 32'hDEAD_BEEF);
        rd_check("wr_rd_105", 16'h0105, 32'hDEAD_BEEF);

        // alias through ignored upper address bits
        wr(16'h1005, 32'hA5A5_A5A5);
        rd_check("alias_005", 16'h0005, 32'hA5A5_A5A5);

        // read then write same address: read sees old data
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_write = 1'b0; bus.mem_addr = 16'h0200;
        @(negedge clk);
        bus.mem_write = 1'b1; bus.mem_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_old", {31'd0, bus.mem_rdata_vld, bus.mem_rdata}, {31'd0, 1'b1, 32'h0000_0200});
        bus.mem_req = 1'b0; bus.mem_write = 1'b0;
        rd_check("rd_new", 16'h0200, 32'h1234_5678);

        // init_go together with a read: read completes, then init runs
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_write = 1'b0; bus.mem_addr = 16'h0123; init_go = 1'b1;
        run_init(-1, nb, ne, nv, ld);
        chk("go_vld_cnt",  64'(nv), 64'd1);
        chk("go_vld_data", 64'(ld), 64'h123);
        chk("go_busy",     64'(nb), 64'd4096);
        chk("go_err",      64'(ne), 64'd0);
        rd_check("reinit_105", 16'h0105, 32'h0000_0105);

        // reset while a read is in flight
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_write = 1'b0; bus.mem_addr = 16'h0005;
        @(negedge clk);
        bus.mem_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld",  64'(bus.mem_rdata_vld), 64'd0);
        chk("mid_rst_busy", 64'(init_busy),         64'd0);
        rst_n = 1'b1;
        run_init(-1, nb, ne, nv, ld);
        chk("rst_init_busy", 64'(nb), 64'd4096);
        chk("rst_no_vld",    64'(nv), 64'd0);
        rd_check("rst_005", 16'h1005, 32'h0000_0005);
        rd_check("rst_000", 16'h0000, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Synthesizable single-port memory responder. It is the target end of the matmul memory interface (mem_req/mem_write/mem_addr/mem_wdata in, mem_rdata_vld/mem_rdata out). It accepts one request per clock and returns read data after a fixed, parameterizable latency. A built-in init sequencer fills the array with an incrementing pattern, so the matmul RTL and gate-level benches can run without backdoor tasks.

Parameters:
MEM_AW, 16, address width of mem_addr
MEM_DW, 32, data width of mem_wdata/mem_rdata
DEPTH_LOG2, 12, log2 of implemented words; must be <= MEM_AW
RD_LAT, 2, read latency in cycles from accepted read to mem_rdata_vld; must be >= 1
INIT_ON_RST, 1, 1 = init sequence starts automatically when rst_n deasserts

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  request strobe; one request accepted per cycle
mem_write  in  1  1 = write, 0 = read; qualified by mem_req
mem_addr  in  MEM_AW  word address
mem_wdata  in  MEM_DW  write data
mem_rdata_vld  out  1  read data valid, one-cycle pulse per read
mem_rdata  out  MEM_DW  read data; 0 when mem_rdata_vld=0
init_go  in  1  pulse that starts an init sequence from READY
init_busy  out  1  high while the init sequence runs
req_err  out  1  one-cycle pulse when mem_req is dropped during init

Behaviour:
- Decided: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: mem_rdata_vld=0, mem_rdata=0, init_busy=0, req_err=0. FSM goes to IDLE. The read pipeline is flushed. Array contents are not reset.
- FSM states: IDLE, INIT, READY.
  - IDLE to INIT on the first clock after reset release if INIT_ON_RST=1; otherwise IDLE to READY.
  - READY to INIT on init_go=1 when no read is in flight. If reads are in flight, init_go is held pending until the pipeline drains.
  - INIT to READY after the last word is written.
  - init_go outside READY is ignored.
- INIT: a counter runs 0..2^DEPTH_LOG2-1 and writes mem[cnt]=cnt, zero-extended to MEM_DW, one word per cycle. init_busy=1 for exactly 2^DEPTH_LOG2 cycles.
- Requests are serviced only in READY. If mem_req=1 in IDLE or INIT, the request is dropped, req_err pulses the next cycle, and no rdata_vld is produced.
- Addressing: only mem_addr[DEPTH_LOG2-1:0] is used. Upper bits are ignored, so the array wraps/aliases every 2^DEPTH_LOG2 words.
- Write: the array is updated at the accepting clock edge. A read accepted the next cycle returns the new data (no bypass needed at this point).
- Read: the array is read at the accepting edge. Data and valid go through RD_LAT-1 further register stages. A read accepted at edge n gives mem_rdata_vld=1 in the cycle after edge n+RD_LAT-1. For RD_LAT=1 that is the cycle right after acceptance.
- Throughput: back-to-back reads every cycle give back-to-back vld pulses, in order, with no gaps.
- Read followed by write to the same address: the read returns the old data.
- Reset mid-operation: in-flight reads are discarded (no vld after reset), init is aborted, and the next init restarts from address 0.
- mem_wdata is ignored on reads; mem_write is ignored when mem_req=0.

Optional Feature:
MEM_RESP_STATS_EN
- Defined: adds output ports rd_cnt[31:0] and wr_cnt[31:0].
  - They count accepted reads and writes in READY; dropped requests and init writes are not counted.
  - Reset to 0 and wrap to 0 after 0xFFFFFFFF.
  - Also adds output err_cnt[15:0], which counts req_err pulses and saturates at 0xFFFF.
- Not defined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- INIT_ON_RST=1, DEPTH_LOG2=12: release rst_n -> init_busy high for exactly 4096 cycles, then low. A read of 0x123 returns mem_rdata=0x00000123.
- RD_LAT=2: write 0x105=0xDEADBEEF at edge n, read 0x105 at edge n+1 -> mem_rdata_vld=1 and mem_rdata=0xDEADBEEF in the cycle after edge n+2, with vld for exactly one cycle.
- Reads of 0x100..0x10F on 16 consecutive cycles -> 16 consecutive vld cycles returning 0x100..0x10F in order, with mem_rdata=0 before and after.
- DEPTH_LOG2=12: write 0x1005=0xA5A5A5A5, then read 0x0005 -> returns 0xA5A5A5A5 (alias).
- mem_req read to 0x010 during INIT -> req_err pulses once, no mem_rdata_vld, and init completes normally.
- Issue a read, then assert rst_n=0 for 1 cycle before its vld -> no vld after reset. With INIT_ON_RST=1, init restarts at address 0.
